// File: rtl/core_mem_pkg.sv
// Shared constants for the core memory arbiter: FSM encoding and arbitration modes.
package core_mem_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT
  } arb_state_e;

endpackage

// File: rtl/arb_picker.sv
// Combinational request picker: fixed priority (lowest index) or round-robin after 'last'.
module arb_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  input  logic             mode,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int p;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    p     = 0;
    for (int k = 0; k < N; k++) begin
      // round-robin scan starts one past the previous winner and wraps
      p = mode ? ((int'(last) + 1 + k) % N) : k;
      if (!any && req[p]) begin
        any      = 1'b1;
        grant[p] = 1'b1;
        idx      = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one memory port among NUM_PORTS requesters, one transaction outstanding at a time.
//   state   | meaning
//   S_IDLE  | no transaction; winner granted via req_ready and latched
//   S_ISSUE | mem_valid high, waiting for mem_ready
//   S_WAIT  | request taken by memory, waiting for mem_rsp_valid
module core_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RR_MODE   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS-1:0]          req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0] req_wstrb,
  output logic [NUM_PORTS-1:0]          req_ready,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          mem_valid,
  output logic                          mem_write,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [DATA_W/8-1:0]           mem_wstrb,
  input  logic                          mem_ready,
  input  logic                          mem_rsp_valid,
  input  logic [DATA_W-1:0]             mem_rsp_rdata,
  output logic                          busy
);

  localparam int   STRB_W = DATA_W / 8;
  localparam int   IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic RR_EN  = (RR_MODE == ARB_RR) && (NUM_PORTS > 1);

  arb_state_e       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] win_idx;
  logic [NUM_PORTS-1:0] win_grant;
  logic             win_any;

  arb_picker #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req_valid),
    .last  (last_q),
    .mode  (RR_EN),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign busy = (state != S_IDLE);

  // gated by reset so every output reads zero while reset is held
  assign req_ready = (state == S_IDLE && reset) ? win_grant : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      owner     <= '0;
      last_q    <= IDX_W'(NUM_PORTS - 1);
      rsp_valid <= '0;
      rsp_rdata <= '0;
      mem_valid <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (win_any) begin
            owner     <= win_idx;
            mem_valid <= 1'b1;
            mem_write <= req_write[win_idx];
            mem_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[win_idx*DATA_W +: DATA_W];
            mem_wstrb <= req_wstrb[win_idx*STRB_W +: STRB_W];
            if (RR_EN) last_q <= win_idx;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            rsp_valid[owner] <= 1'b1;
            rsp_rdata        <= mem_write ? '0 : mem_rsp_rdata;
            state            <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: a 2-port fixed-priority and a 3-port round-robin instance.
module tb_core_mem_arbiter;

  typedef struct packed {
    logic [2:0]  rdy;
    logic [2:0]  rsp;
    logic [31:0] rdata;
    logic        mv;
    logic        mw;
    logic [31:0] ma;
    logic [31:0] md;
    logic [3:0]  ms;
    logic        busy;
  } obs_t;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid [2];
  logic [2:0]  req_write [2];
  logic [95:0] req_addr  [2];
  logic [95:0] req_wdata [2];
  logic [11:0] req_wstrb [2];
  logic        mem_ready     [2];
  logic        mem_rsp_valid [2];
  logic [31:0] mem_rsp_rdata [2];
  obs_t        obs [2];

  logic [1:0]  a_rdy, a_rsp;
  logic [31:0] a_rdata, a_ma, a_md;
  logic        a_mv, a_mw, a_busy;
  logic [3:0]  a_ms;
  logic [2:0]  b_rdy, b_rsp;
  logic [31:0] b_rdata, b_ma, b_md;
  logic        b_mv, b_mw, b_busy;
  logic [3:0]  b_ms;

  int n_vec = 0;
  int n_bad = 0;

  core_mem_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0][1:0]), .req_write(req_write[0][1:0]),
    .req_addr(req_addr[0][63:0]), .req_wdata(req_wdata[0][63:0]), .req_wstrb(req_wstrb[0][7:0]),
    .req_ready(a_rdy), .rsp_valid(a_rsp), .rsp_rdata(a_rdata),
    .mem_valid(a_mv), .mem_write(a_mw), .mem_addr(a_ma), .mem_wdata(a_md), .mem_wstrb(a_ms),
    .mem_ready(mem_ready[0]), .mem_rsp_valid(mem_rsp_valid[0]), .mem_rsp_rdata(mem_rsp_rdata[0]),
    .busy(a_busy)
  );

  core_mem_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .RR_MODE(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .req_ready(b_rdy), .rsp_valid(b_rsp), .rsp_rdata(b_rdata),
    .mem_valid(b_mv), .mem_write(b_mw), .mem_addr(b_ma), .mem_wdata(b_md), .mem_wstrb(b_ms),
    .mem_ready(mem_ready[1]), .mem_rsp_valid(mem_rsp_valid[1]), .mem_rsp_rdata(mem_rsp_rdata[1]),
    .busy(b_busy)
  );

  assign obs[0] = {1'b0, a_rdy, 1'b0, a_rsp, a_rdata, a_mv, a_mw, a_ma, a_md, a_ms, a_busy};
  assign obs[1] = {b_rdy, b_rsp, b_rdata, b_mv, b_mw, b_ma, b_md, b_ms, b_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs(input int d);
    req_valid[d] = '0; req_write[d] = '0; req_addr[d] = '0;
    req_wdata[d] = '0; req_wstrb[d] = '0;
    mem_ready[d] = 1'b0; mem_rsp_valid[d] = 1'b0; mem_rsp_rdata[d] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs(0);
    clear_inputs(1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Reference arbitration rule: lowest index, or first requester after the previous winner.
  function automatic int pick(input logic [2:0] v, input int n, input int rr, input int lastp);
    for (int k = 1; k <= n; k++) begin
      int p;
      p = (rr != 0) ? ((lastp + k) % n) : (k - 1);
      if (v[p]) return p;
    end
    return -1;
  endfunction

  // Transaction-level model: one transaction in flight, taken by memory once, completed by a later response.
  task automatic run_random(input int d, input int n, input int rr, input int ncyc);
    bit          act, acked;
    int          own, acc, pend, lastp, w;
    logic        wr;
    logic [31:0] ad, wd, er;
    logic [3:0]  ws;
    logic [2:0]  exp_rdy, exp_rsp;
    obs_t        o;
    do_reset();
    act = 0; acked = 0; own = 0; acc = -1; pend = -1; lastp = n - 1; er = '0;
    wr = 1'b0; ad = '0; wd = '0; ws = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (acc >= 0) req_valid[d][acc] = 1'b0;
      acc = -1;
      for (int p = 0; p < n; p++) begin
        if (!req_valid[d][p] && ($urandom_range(1, 0) == 1)) begin
          req_valid[d][p]           = 1'b1;
          req_write[d][p]           = 1'($urandom_range(1, 0));
          req_addr[d][p*32 +: 32]   = $urandom;
          req_wdata[d][p*32 +: 32]  = $urandom;
          req_wstrb[d][p*4 +: 4]    = 4'($urandom_range(15, 0));
        end
      end
      mem_ready[d]     = 1'($urandom_range(1, 0));
      mem_rsp_valid[d] = ($urandom_range(2, 0) == 0);
      mem_rsp_rdata[d] = $urandom;
      #1;
      o = obs[d];
      w = act ? -1 : pick(req_valid[d], n, rr, lastp);
      exp_rdy = (w >= 0) ? 3'(1 << w) : 3'b000;
      exp_rsp = (pend >= 0) ? 3'(1 << pend) : 3'b000;
      chk("rnd_ready",  128'(o.rdy),   128'(exp_rdy));
      chk("rnd_busy",   128'(o.busy),  128'(act));
      chk("rnd_mvalid", 128'(o.mv),    128'(act && !acked));
      chk("rnd_rsp",    128'(o.rsp),   128'(exp_rsp));
      chk("rnd_rdata",  128'(o.rdata), 128'(er));
      if (act) begin
        chk("rnd_mwrite", 128'(o.mw), 128'(wr));
        chk("rnd_maddr",  128'(o.ma), 128'(ad));
        chk("rnd_mwdata", 128'(o.md), 128'(wd));
        chk("rnd_mwstrb", 128'(o.ms), 128'(ws));
      end
      pend = -1;
      if (!act) begin
        if (w >= 0) begin
          act = 1; acked = 0; own = w; acc = w;
          wr = req_write[d][w];
          ad = req_addr[d][w*32 +: 32];
          wd = req_wdata[d][w*32 +: 32];
          ws = req_wstrb[d][w*4 +: 4];
          if (rr != 0) lastp = w;
        end
      end else if (!acked) begin
        if (mem_ready[d]) acked = 1;
      end else if (mem_rsp_valid[d]) begin
        pend = own;
        er   = wr ? 32'h0 : mem_rsp_rdata[d];
        act  = 0;
      end
    end
  endtask

  initial begin
    int          grants [$];
    int          cnt [3];
    int          nacc;
    logic [2:0]  exp_order [6];
    reset = 1'b0;
    clear_inputs(0);
    clear_inputs(1);
    #1;
    chk("reset_outs_a", 128'(obs[0]), 128'(0));
    chk("reset_outs_b", 128'(obs[1]), 128'(0));
    do_reset();

    // single read on port 1, minimum latency
    @(negedge clk);
    req_valid[0] = 3'b010; req_write[0] = 3'b000; req_addr[0][63:32] = 32'h0000_0040;
    #1 chk("sr_ready", 128'(obs[0].rdy), 128'(3'b010));
    @(negedge clk);
    req_valid[0] = 3'b000; mem_ready[0] = 1'b1;
    #1 chk("sr_mvalid", 128'(obs[0].mv), 128'(1));
    chk("sr_maddr", 128'(obs[0].ma), 128'(32'h40));
    chk("sr_busy1", 128'(obs[0].busy), 128'(1));
    @(negedge clk);
    mem_ready[0] = 1'b0; mem_rsp_valid[0] = 1'b1; mem_rsp_rdata[0] = 32'hDEAD_BEEF;
    #1 chk("sr_mvalid_drop", 128'(obs[0].mv), 128'(0));
    chk("sr_busy2", 128'(obs[0].busy), 128'(1));
    @(negedge clk);
    mem_rsp_valid[0] = 1'b1; mem_rsp_rdata[0] = 32'h1111_1111;
    #1 chk("sr_rsp", 128'(obs[0].rsp), 128'(3'b010));
    chk("sr_rdata", 128'(obs[0].rdata), 128'(32'hDEAD_BEEF));
    chk("sr_idle", 128'(obs[0].busy), 128'(0));
    @(negedge clk);
    mem_rsp_valid[0] = 1'b0;
    #1 chk("stray_idle_rsp", 128'(obs[0].rsp), 128'(0));
    chk("rdata_hold", 128'(obs[0].rdata), 128'(32'hDEAD_BEEF));

    // write with memory backpressure, stray response alongside mem_ready
    @(negedge clk);
    req_valid[0] = 3'b001; req_write[0] = 3'b001;
    req_addr[0][31:0] = 32'h100; req_wdata[0][31:0] = 32'h1234_5678; req_wstrb[0][3:0] = 4'b0011;
    #1 chk("bp_ready", 128'(obs[0].rdy), 128'(3'b001));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid[0] = 3'b010; req_addr[0][63:32] = 32'h200;
      mem_ready[0] = (i == 5); mem_rsp_valid[0] = (i == 5);
      #1 chk("bp_mvalid", 128'(obs[0].mv), 128'(1));
      chk("bp_mwrite", 128'(obs[0].mw), 128'(1));
      chk("bp_maddr", 128'(obs[0].ma), 128'(32'h100));
      chk("bp_mwdata", 128'(obs[0].md), 128'(32'h1234_5678));
      chk("bp_mwstrb", 128'(obs[0].ms), 128'(4'b0011));
      chk("bp_other_ready", 128'(obs[0].rdy), 128'(0));
    end
    @(negedge clk);
    mem_ready[0] = 1'b0; mem_rsp_valid[0] = 1'b0;
    #1 chk("bp_wait_rsp", 128'(obs[0].rsp), 128'(0));
    chk("bp_wait_mvalid", 128'(obs[0].mv), 128'(0));
    @(negedge clk);
    mem_rsp_valid[0] = 1'b1; mem_rsp_rdata[0] = 32'hFFFF_FFFF;
    #1 chk("bp_no_early_rsp", 128'(obs[0].rsp), 128'(0));
    @(negedge clk);
    mem_rsp_valid[0] = 1'b0;
    #1 chk("bp_rsp", 128'(obs[0].rsp), 128'(3'b001));
    chk("bp_wr_rdata", 128'(obs[0].rdata), 128'(0));
    chk("bp_b2b_ready", 128'(obs[0].rdy), 128'(3'b010));

    // fixed priority: port 1 starves while port 0 keeps requesting
    do_reset();
    nacc = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      req_valid[0] = 3'b011; mem_ready[0] = 1'b1; mem_rsp_valid[0] = 1'b1;
      #1 chk("fp_ready1", 128'(obs[0].rdy[1]), 128'(0));
      chk("fp_rsp1", 128'(obs[0].rsp[1]), 128'(0));
      if (obs[0].rdy[0]) nacc++;
    end
    chk("fp_grants", 128'(nacc), 128'(3));

    // round-robin across three ports, then reset while waiting for a response
    do_reset();
    cnt = '{0, 0, 0};
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      req_valid[1] = 3'b111; mem_ready[1] = 1'b1; mem_rsp_valid[1] = 1'b1;
      #1;
      for (int p = 0; p < 3; p++) begin
        if (obs[1].rdy[p]) grants.push_back(p);
        if (obs[1].rsp[p]) cnt[p]++;
      end
    end
    exp_order = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
    chk("rr_ngrants", 128'(grants.size() >= 6), 128'(1));
    for (int i = 0; i < 6 && i < grants.size(); i++)
      chk("rr_order", 128'(grants[i]), 128'(exp_order[i]));
    for (int p = 0; p < 3; p++) chk("rr_share", 128'(cnt[p]), 128'(2));
    @(negedge clk);
    mem_rsp_valid[1] = 1'b0;
    @(negedge clk);
    #1 chk("rr_wait_busy", 128'(obs[1].busy), 128'(1));
    #1 reset = 1'b0;
    #1 chk("rst_async_b", 128'(obs[1]), 128'(0));
    chk("rst_async_a", 128'(obs[0]), 128'(0));
    @(negedge clk);
    reset = 1'b1; mem_rsp_valid[1] = 1'b1;
    #1 chk("rst_first_grant", 128'(obs[1].rdy), 128'(3'b001));
    chk("rst_busy", 128'(obs[1].busy), 128'(0));
    req_valid[1] = 3'b000;
    @(negedge clk);
    #1 chk("rst_no_rsp", 128'(obs[1].rsp), 128'(0));
    chk("rst_idle", 128'(obs[1].busy), 128'(0));

    run_random(0, 2, 0, 800);
    run_random(1, 3, 1, 800);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
